valid_burst_gen: RTL and testbench
==================================

Name: valid_burst_gen

Overview:
- Transmit-side companion to the valid-pulse counter: emits a programmed burst of single-cycle valid strobes with payload, then waits for the counter's alarm as burst acknowledge.
- Sits upstream of the counter: o_valid drives the counter's valid input, and the counter's alarm output returns on i_alarm_cnt.
- Also tracks completed bursts and flags protocol errors.

Parameters:
- NB_DATA, 160, payload width.
- NB_CNT, 64, width of the completed-burst counter.
- BURST_LEN, 8, strobes per burst; must equal the counter's terminal count; minimum 1.
- NB_GAP, 8, width of the inter-strobe gap field.
- ACK_TIMEOUT, 4, cycles allowed for the alarm after the last strobe; minimum 1.

Ports:
- i_clock, in, 1, clock; all logic on rising edge.
- i_reset, in, 1, synchronous, active-high reset.
- i_start, in, 1, start-burst request; sampled only in IDLE.
- i_gap, in, NB_GAP, idle cycles inserted between strobes; latched at start.
- i_seed, in, NB_DATA, first payload word; latched at start.
- i_alarm_cnt, in, 1, counter alarm, used as burst acknowledge.
- o_valid, out, 1, single-cycle payload strobe.
- o_data, out, NB_DATA, payload; meaningful only while o_valid=1.
- o_busy, out, 1, high in every state except IDLE.
- o_done, out, 1, one-cycle pulse when a burst is acknowledged.
- o_error, out, 1, sticky protocol-error flag.
- o_burst_count, out, NB_CNT, number of acknowledged bursts.

Behaviour:
- Reset (synchronous, highest priority, any state): state=IDLE and all outputs 0, including o_data, o_burst_count and o_error. Reset mid-burst abandons the burst with no o_done.
- All outputs are registered.
- FSM states: IDLE, SEND, GAP, WAIT_ACK, DONE.
- IDLE:
  - i_start=1 latches i_gap and i_seed, clears the strobe index, and enters SEND next cycle.
  - i_start in any other state is ignored.
- SEND:
  - o_valid=1 for exactly one cycle, with o_data = current payload; the strobe index increments.
  - If the index has reached BURST_LEN, go to WAIT_ACK.
  - Else, if latched gap = 0, stay in SEND (back-to-back strobes).
  - Else go to GAP.
- GAP: hold for exactly the latched gap count of cycles with o_valid=0, then return to SEND.
- Payload: first strobe carries the seed; each later strobe carries the previous payload + 1, modulo 2^NB_DATA (wraps silently).
- WAIT_ACK:
  - i_alarm_cnt=1 within cycles 1..ACK_TIMEOUT after entry goes to DONE.
  - No alarm by the end of cycle ACK_TIMEOUT sets o_error and goes to DONE without acknowledge.
- DONE (one cycle):
  - If acknowledged: o_done=1 and o_burst_count increments, wrapping at 2^NB_CNT.
  - Then return to IDLE.
- i_alarm_cnt=1 in SEND or GAP is an early alarm: set o_error and continue the burst unchanged.
- o_error clears only on reset.
- Fastest burst (gap 0): start cycle, then BURST_LEN strobe cycles, then alarm on the first WAIT_ACK cycle, then DONE. o_done rises BURST_LEN+2 cycles after the start cycle.

Optional Feature:
- Macro VALID_BURST_GEN_LFSR_EN.
- Defined: payload advances through a maximal-length Fibonacci LFSR over the low 32 bits, taps 32,22,2,1. Upper bits hold the seed. A seed whose low 32 bits are zero is forced to 32'h1 at latch.
- Undefined: incrementing payload as in Behaviour; no LFSR logic is synthesized.

Decomposition:
- Package valid_burst_gen_pkg holds:
  - the state typedef (IDLE..DONE, binary encoded);
  - the LFSR tap constant and nonzero-seed constant;
  - the default BURST_LEN and ACK_TIMEOUT localparams, shared with the counter's MAX_COUNT.
- One sub-module, payload_next: combinational next-payload function (increment, or LFSR under the macro), instantiated once.

Test Plan:
- Reset then i_start, gap 0, seed 0x10, model counter returning alarm 1 cycle after the 8th strobe -> 8 consecutive strobes with data 0x10..0x17, o_done on cycle 10 after start, o_burst_count=1, o_error=0.
- Gap 3 -> each strobe separated by exactly 3 idle cycles; burst spans 8+7*3=29 strobe/gap cycles; o_done pulse follows.
- Alarm held low -> after ACK_TIMEOUT=4 cycles o_error=1, no o_done, o_burst_count unchanged, back to IDLE; o_error stays 1 into the next burst.
- Alarm forced high during the 4th strobe -> o_error=1 immediately, burst still emits all 8 strobes.
- i_reset asserted during the 5th GAP cycle -> next cycle all outputs 0, state IDLE; a new i_start runs a clean burst.
- Seed 2^NB_DATA-2 -> payloads wrap to 0 after all-ones; with the LFSR macro and seed 0, first payload low word = 0x1.

Source files
------------

// File: rtl/valid_burst_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : valid_burst_gen_pkg
// Purpose  : Shared types and constants for the valid-burst generator.
//            Holds the FSM state encoding, the LFSR tap/seed constants used
//            when VALID_BURST_GEN_LFSR_EN is defined, and the default burst
//            geometry shared with the downstream valid-pulse counter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package valid_burst_gen_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND     = 3'd1,
    GAP      = 3'd2,
    WAIT_ACK = 3'd3,
    DONE     = 3'd4
  } state_t;

  // Fibonacci LFSR taps 32,22,2,1 expressed as a bit mask over [31:0].
  localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
  // An all-zero LFSR state would lock up, so a zero seed is replaced by this.
  localparam logic [31:0] LFSR_SEED_NZ = 32'h0000_0001;

  // Must match the counter's MAX_COUNT so its alarm lands after the last strobe.
  localparam int DEF_BURST_LEN   = 8;
  localparam int DEF_ACK_TIMEOUT = 4;

endpackage
`default_nettype wire

// File: rtl/valid_burst_gen_payload_next.sv
`default_nettype none
// ============================================================================
// Module   : payload_next
// Purpose  : Combinational next-payload function.
//            Default build : nxt = cur + 1 (wraps modulo 2^NB_DATA).
//            VALID_BURST_GEN_LFSR_EN : low 32 bits advance one step of a
//            maximal-length Fibonacci LFSR, upper bits pass through.
// Ports    : cur [NB_DATA] in  - current payload word
//            nxt [NB_DATA] out - payload word for the following strobe
// Revision : 1.0 - initial release
// ============================================================================
module payload_next
  import valid_burst_gen_pkg::*;
#(
  parameter int NB_DATA = 160
) (
  input  logic [NB_DATA-1:0] cur,
  output logic [NB_DATA-1:0] nxt
);

`ifdef VALID_BURST_GEN_LFSR_EN
  // Shift toward the MSB, feedback enters at bit 0. Requires NB_DATA > 32.
  always_comb begin
    nxt       = cur;
    nxt[31:0] = {cur[30:0], ^(cur[31:0] & LFSR_TAPS)};
  end
`else
  always_comb begin
    nxt = cur + NB_DATA'(1);
  end
`endif

endmodule
`default_nettype wire

// File: rtl/valid_burst_gen.sv
`default_nettype none
// ============================================================================
// Module   : valid_burst_gen
// Purpose  : Emits a burst of BURST_LEN single-cycle valid strobes with
//            payload, optionally spaced by a programmable gap, then waits up
//            to ACK_TIMEOUT cycles for the counter alarm as acknowledge.
//            Counts acknowledged bursts and keeps a sticky protocol-error flag
//            (ack timeout, or alarm seen while the burst is still running).
// Ports    : i_clock       in   1        clock, rising edge
//            i_reset       in   1        synchronous active-high reset
//            i_start       in   1        start request, sampled in IDLE only
//            i_gap         in   NB_GAP   idle cycles between strobes
//            i_seed        in   NB_DATA  first payload word
//            i_alarm_cnt   in   1        counter alarm (burst acknowledge)
//            o_valid       out  1        single-cycle payload strobe
//            o_data        out  NB_DATA  payload, meaningful with o_valid
//            o_busy        out  1        high outside IDLE
//            o_done        out  1        pulse on acknowledged burst
//            o_error       out  1        sticky protocol error
//            o_burst_count out  NB_CNT   acknowledged bursts (wraps)
// Macro    : VALID_BURST_GEN_LFSR_EN selects LFSR payload sequencing.
// Revision : 1.0 - initial release
// ============================================================================
module valid_burst_gen
  import valid_burst_gen_pkg::*;
#(
  parameter int NB_DATA     = 160,
  parameter int NB_CNT      = 64,
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int NB_GAP      = 8,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_GAP-1:0]  i_gap,
  input  logic [NB_DATA-1:0] i_seed,
  input  logic               i_alarm_cnt,
  output logic               o_valid,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error,
  output logic [NB_CNT-1:0]  o_burst_count
);

  localparam int IW = $clog2(BURST_LEN) + 1;
  localparam int AW = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BURST_LEN - 1);
  localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TIMEOUT - 1);

  state_t               state, state_nxt;
  logic [IW-1:0]        idx;
  logic [NB_GAP-1:0]    gap_lat;
  logic [NB_GAP-1:0]    gap_cnt;
  logic [AW-1:0]        ack_cnt;
  logic [NB_DATA-1:0]   payload;
  logic [NB_DATA-1:0]   payload_adv;
  logic [NB_DATA-1:0]   seed_eff;
  logic                 ack_hit;
  logic                 timeout_hit;
  logic                 early_alarm;

  payload_next #(.NB_DATA(NB_DATA)) u_payload_next (
    .cur (payload),
    .nxt (payload_adv)
  );

`ifdef VALID_BURST_GEN_LFSR_EN
  always_comb begin
    seed_eff = i_seed;
    if (i_seed[31:0] == 32'h0) seed_eff[31:0] = LFSR_SEED_NZ;
  end
`else
  always_comb begin
    seed_eff = i_seed;
  end
`endif

  // Next-state logic; also flags the WAIT_ACK exit reason for the registers.
  always_comb begin
    state_nxt   = state;
    ack_hit     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) state_nxt = SEND;
      end
      SEND: begin
        // idx counts strobes already sent before this one.
        if (idx == LAST_IDX)      state_nxt = WAIT_ACK;
        else if (gap_lat == '0)   state_nxt = SEND;
        else                      state_nxt = GAP;
      end
      GAP: begin
        if (gap_cnt == '0) state_nxt = SEND;
      end
      WAIT_ACK: begin
        if (i_alarm_cnt) begin
          ack_hit   = 1'b1;
          state_nxt = DONE;
        end else if (ack_cnt == ACK_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign early_alarm = i_alarm_cnt && ((state == SEND) || (state == GAP));

  // Every output is a flop whose D input is derived from state_nxt, so the
  // outputs line up with the state they describe.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= IDLE;
      idx           <= '0;
      gap_lat       <= '0;
      gap_cnt       <= '0;
      ack_cnt       <= '0;
      payload       <= '0;
      o_valid       <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_error       <= 1'b0;
      o_burst_count <= '0;
    end else begin
      state   <= state_nxt;
      o_valid <= (state_nxt == SEND);
      o_busy  <= (state_nxt != IDLE);
      o_done  <= ack_hit;
      if (timeout_hit || early_alarm) o_error <= 1'b1;
      if (ack_hit) o_burst_count <= o_burst_count + NB_CNT'(1);

      case (state)
        IDLE: begin
          if (i_start) begin
            gap_lat <= i_gap;
            payload <= seed_eff;
            idx     <= '0;
          end
        end
        SEND: begin
          idx     <= idx + IW'(1);
          payload <= payload_adv;
          // Loaded with gap-1 so GAP exits when the counter reads zero;
          // unused when the latched gap is zero.
          gap_cnt <= gap_lat - NB_GAP'(1);
          ack_cnt <= '0;
        end
        GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - NB_GAP'(1);
        end
        WAIT_ACK: begin
          ack_cnt <= ack_cnt + AW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // The payload register is the data output: it holds the word for the
  // current strobe and advances at the end of each SEND cycle.
  assign o_data = payload;

endmodule
`default_nettype wire

// File: tb/tb_valid_burst_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_valid_burst_gen
// Purpose  : Directed self-checking bench for valid_burst_gen. Drives bursts
//            with various gaps and seeds, plays the counter's alarm by hand,
//            and compares every output against hand-derived values.
// Ports    : none
// Macro    : VALID_BURST_GEN_LFSR_EN switches the payload model to the LFSR.
// Revision : 1.0 - initial release
// ============================================================================
module tb_valid_burst_gen;

  localparam int NB_DATA = 160;
  localparam int NB_CNT  = 64;
  localparam int NB_GAP  = 8;
  localparam int BLEN    = 8;
  localparam int ATO     = 4;

  logic               clk;
  logic               rst;
  logic               start;
  logic [NB_GAP-1:0]  gap;
  logic [NB_DATA-1:0] seed;
  logic               alarm;
  logic               valid;
  logic [NB_DATA-1:0] data;
  logic               busy;
  logic               done;
  logic               error;
  logic [NB_CNT-1:0]  burst_count;

  int total;
  int bad;

  valid_burst_gen #(
    .NB_DATA     (NB_DATA),
    .NB_CNT      (NB_CNT),
    .BURST_LEN   (BLEN),
    .NB_GAP      (NB_GAP),
    .ACK_TIMEOUT (ATO)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_start       (start),
    .i_gap         (gap),
    .i_seed        (seed),
    .i_alarm_cnt   (alarm),
    .o_valid       (valid),
    .o_data        (data),
    .o_busy        (busy),
    .o_done        (done),
    .o_error       (error),
    .o_burst_count (burst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [NB_DATA-1:0] got,
                       input logic [NB_DATA-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Independent payload model.
  function automatic logic [NB_DATA-1:0] model_seed(input logic [NB_DATA-1:0] s);
    logic [NB_DATA-1:0] r;
    r = s;
`ifdef VALID_BURST_GEN_LFSR_EN
    if (r[31:0] == 32'h0) r[31:0] = 32'h1;
`endif
    return r;
  endfunction

  function automatic logic [NB_DATA-1:0] model_next(input logic [NB_DATA-1:0] v);
    logic [NB_DATA-1:0] r;
`ifdef VALID_BURST_GEN_LFSR_EN
    logic fb;
    fb = v[31] ^ v[21] ^ v[1] ^ v[0];
    r = {v[NB_DATA-1:32], v[30:0], fb};
`else
    r = v + 1'b1;
`endif
    return r;
  endfunction

  // Starts a burst and checks every strobe/gap cycle. early_at (1-based)
  // raises the alarm during that strobe; 0 means no early alarm.
  // Returns positioned on the first WAIT_ACK cycle.
  task automatic send_burst(input logic [NB_DATA-1:0] s, input int g, input int early_at);
    logic [NB_DATA-1:0] exp;
    exp   = model_seed(s);
    start = 1'b1;
    gap   = NB_GAP'(g);
    seed  = s;
    tick;
    start = 1'b0;
    for (int k = 1; k <= BLEN; k++) begin
      if (k == early_at) alarm = 1'b1;
      check($sformatf("strobe%0d_valid", k), {159'd0, valid}, 160'd1);
      check($sformatf("strobe%0d_data", k), data, exp);
      exp = model_next(exp);
      tick;
      alarm = 1'b0;
      if (k == early_at) check("early_err", {159'd0, error}, 160'd1);
      if (k != BLEN) begin
        for (int j = 0; j < g; j++) begin
          check($sformatf("gap%0d_%0d_valid", k, j), {159'd0, valid}, 160'd0);
          check($sformatf("gap%0d_%0d_busy", k, j), {159'd0, busy}, 160'd1);
          tick;
        end
      end
    end
  endtask

  // Raise the alarm on WAIT_ACK cycle w and check the DONE pulse.
  task automatic ack_at(input int w, input logic [NB_CNT-1:0] exp_cnt);
    for (int c = 1; c < w; c++) begin
      check($sformatf("wait%0d_done", c), {159'd0, done}, 160'd0);
      tick;
    end
    check("wait_valid", {159'd0, valid}, 160'd0);
    check("wait_busy", {159'd0, busy}, 160'd1);
    check("wait_done", {159'd0, done}, 160'd0);
    alarm = 1'b1;
    tick;
    alarm = 1'b0;
    check("done_pulse", {159'd0, done}, 160'd1);
    check("done_count", {96'd0, burst_count}, {96'd0, exp_cnt});
    tick;
    check("after_done", {159'd0, done}, 160'd0);
    check("after_busy", {159'd0, busy}, 160'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {159'd0, valid}, 160'd0);
    check({tag, "_data"}, data, 160'd0);
    check({tag, "_busy"}, {159'd0, busy}, 160'd0);
    check({tag, "_done"}, {159'd0, done}, 160'd0);
    check({tag, "_error"}, {159'd0, error}, 160'd0);
    check({tag, "_count"}, {96'd0, burst_count}, 160'd0);
  endtask

  initial begin
    logic [NB_DATA-1:0] wrap_seed;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    gap   = '0;
    seed  = '0;
    alarm = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    tick;
    check_all_zero("reset");

    // Fastest burst: seed 0x10, gap 0, alarm on the first WAIT_ACK cycle;
    // o_done lands 10 cycles after the start cycle.
    send_burst(160'h10, 0, 0);
    ack_at(1, 64'd1);
    check("b1_error", {159'd0, error}, 160'd0);

    // Gap 3, acknowledge on the last allowed WAIT_ACK cycle.
    send_burst(160'h100, 3, 0);
    ack_at(ATO, 64'd2);
    check("b2_error", {159'd0, error}, 160'd0);

    // No alarm: timeout sets error, no done, count unchanged.
    send_burst(160'h20, 0, 0);
    for (int c = 1; c <= ATO; c++) begin
      check($sformatf("to_wait%0d_done", c), {159'd0, done}, 160'd0);
      check($sformatf("to_wait%0d_err", c), {159'd0, error}, 160'd0);
      tick;
    end
    check("to_done_cycle_done", {159'd0, done}, 160'd0);
    check("to_done_cycle_err", {159'd0, error}, 160'd1);
    check("to_done_cycle_busy", {159'd0, busy}, 160'd1);
    check("to_count", {96'd0, burst_count}, 160'd2);
    tick;
    check("to_idle_busy", {159'd0, busy}, 160'd0);
    // Error is sticky into the next, successful burst.
    send_burst(160'h30, 0, 0);
    ack_at(1, 64'd3);
    check("sticky_err", {159'd0, error}, 160'd1);

    // Early alarm during the 4th strobe: error now, burst still complete.
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_all_zero("rst2");
    send_burst(160'h200, 1, 4);
    ack_at(1, 64'd1);
    check("early_err_sticky", {159'd0, error}, 160'd1);

    // Reset during the 5th GAP cycle (gap 3: second cycle of second gap).
    start = 1'b1;
    gap   = 8'd3;
    seed  = 160'h40;
    tick;
    start = 1'b0;
    check("r_s1_valid", {159'd0, valid}, 160'd1);
    for (int c = 0; c < 3; c++) tick;
    tick;
    check("r_s2_valid", {159'd0, valid}, 160'd1);
    check("r_s2_data", data, model_next(model_seed(160'h40)));
    tick;
    tick;
    check("r_gap5_valid", {159'd0, valid}, 160'd0);
    check("r_gap5_busy", {159'd0, busy}, 160'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_all_zero("midrst");
    for (int c = 0; c < 6; c++) begin
      check($sformatf("midrst_idle%0d", c), {158'd0, valid, busy}, 160'd0);
      tick;
    end
    send_burst(160'h50, 0, 0);
    ack_at(1, 64'd1);
    check("clean_err", {159'd0, error}, 160'd0);

    // Seed near all-ones: increment wraps through zero.
    wrap_seed = '1;
    wrap_seed = wrap_seed - 160'd1;
    send_burst(wrap_seed, 0, 0);
    ack_at(1, 64'd2);

`ifdef VALID_BURST_GEN_LFSR_EN
    // Zero seed is forced to a nonzero LFSR state.
    start = 1'b1;
    gap   = 8'd0;
    seed  = '0;
    tick;
    start = 1'b0;
    check("lfsr_zero_seed", data, 160'h1);
    for (int c = 0; c < BLEN; c++) tick;
    alarm = 1'b1;
    tick;
    alarm = 1'b0;
    check("lfsr_done", {159'd0, done}, 160'd1);
    tick;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
